pong_probe_trace: RTL and testbench
===================================

// Module: pong_probe_trace
// PURPOSE
//  Parametrised trace recorder for game-state debug: snapshots NUM_CH probe channels (ball/paddle x,y)
//  on each frame_start rising edge into a DEPTH-record FIFO; host/bench drains it via valid/ready word stream.
//  Sits beside display_pong, fed from its position registers; replaces passive position taps.
// PARAMETERS
//  NUM_CH  4   probe channels per record (>=1)
//  CH_W    10  bits per channel
//  DEPTH   16  records in FIFO (power of 2, >=2)
//  DECIM   1   capture every DECIM-th qualifying frame (>=1)
//  TS_W    16  frame-timestamp width (used only with PROBE_TIMESTAMP_EN)
// PORTS
//  clk          in   1              system clock, all logic rising-edge
//  reset_in     in   1              asynchronous, active-low reset
//  probe_data   in   NUM_CH*CH_W    channel k = bits [k*CH_W +: CH_W]
//  frame_start  in   1              level; rising edge = capture opportunity
//  arm          in   1              1-cycle pulse: flush + start capture in mode_sel
//  mode_sel     in   2              0 continuous, 1 one-shot, 2 change-only, 3 = treated as 0
//  rd_data      out  CH_W           current word (channel rd_idx of head record)
//  rd_ts        out  TS_W           timestamp of head record (0 when feature off)
//  rd_valid     out  1              FIFO non-empty
//  rd_ready     in   1              word accepted when rd_valid & rd_ready
//  rd_last      out  1              current word is channel NUM_CH-1
//  count        out  $clog2(DEPTH+1) stored records
//  overflow     out  1              sticky: record dropped because FIFO full
//  busy         out  1              state == RUN
// BEHAVIOUR
//  Reset (reset_in=0, async): state IDLE, FIFO empty, count=0, rd_valid=0, rd_last=0, rd_data=0,
//   rd_ts=0, overflow=0, busy=0, rd_idx=0, decim cnt=0, edge reg=0, timestamp=0, mode reg=0.
//  Edge detect: fs_q <= frame_start; edge = frame_start & ~fs_q (edge in same cycle as rise).
//  FSM: IDLE -arm-> RUN; RUN -arm-> RUN (restart); RUN -(mode1 & count reaches DEPTH)-> DONE;
//   DONE -arm-> RUN. No other transitions. mode_sel latched only on arm.
//  arm (any state): FIFO flushed, count=0, overflow=0, rd_idx=0, decim cnt=0, change-ref invalid;
//   arm wins over capture and pop in the same cycle.
//  Qualifying edge: edge & state==RUN & (mode!=2 | ref invalid | probe_data != last written record).
//  Decimation: counter 0..DECIM-1 advances per qualifying edge; write only when counter==0.
//  Write: at clock edge ending the edge cycle; record = probe_data sampled that cycle;
//   count/rd_valid reflect it next cycle (latency 1). Change-ref updated only on actual write.
//  Full (count==DEPTH): mode 0/2: record dropped, overflow<=1 (unless last-word pop same cycle,
//   then write accepted, count unchanged). Mode 1: FSM already in DONE, no drop, overflow stays 0.
//  Read: rd_valid = count!=0; rd_data = head[rd_idx]; rd_last = rd_idx==NUM_CH-1.
//   Accept non-last word: rd_idx++. Accept last word: rd_idx=0, head pops, count--.
//   rd_data/rd_ts hold stable while rd_valid & ~rd_ready. Empty: rd_data=0, rd_last=0.
//  Simultaneous write + pop: count unchanged, both take effect. Pointers log2(DEPTH) bits, wrap.
//  Reads permitted in any state (drain after DONE or IDLE).
// CONFIGURATION
//  PROBE_TIMESTAMP_EN defined: TS_W-bit frame counter increments on every frame_start rising
//   edge (any state, wraps 2^TS_W-1 -> 0, not cleared by arm); stored with each record, shown on rd_ts.
//  Undefined: no counter or storage; rd_ts tied 0.
// TESTING
//  Reset mid-RUN with 3 records stored -> all outputs reset values next cycle, count=0, busy=0.
//  Mode0 DEPTH=16, ball_x=100..119 over 20 frames, no reads -> count=16, overflow=1,
//   drain yields ball_x 100..115 in order, rd_last every 4th word.
//  Mode1, 20 frames -> DONE after 16th, busy=0, overflow=0; arm -> count=0, busy=1.
//  Mode2, probe_data constant 5 frames then change -> exactly 2 records; DECIM=3 mode0 9 frames -> 3.
//  Full FIFO, last-word accept in same cycle as edge -> count stays 16, overflow=0, new record at tail.
//  PROBE_TIMESTAMP_EN, TS_W=4, 18 frames, mode0 reads keep pace -> rd_ts 0..15,0,1 (wrap).

Source files
------------

// File: rtl/pong_probe_trace.sv
// Frame-synchronous trace recorder for pong game-state probes, drained as a valid/ready word stream.
// Optional per-record frame timestamps are built when PROBE_TIMESTAMP_EN is defined.
module pong_probe_trace #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 10,
  parameter int DEPTH  = 16,
  parameter int DECIM  = 1,
  parameter int TS_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset_in,
  input  logic [NUM_CH*CH_W-1:0]     probe_data,
  input  logic                       frame_start,
  input  logic                       arm,
  input  logic [1:0]                 mode_sel,
  output logic [CH_W-1:0]            rd_data,
  output logic [TS_W-1:0]            rd_ts,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic                       rd_last,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int REC_W = NUM_CH * CH_W;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t             state_r, state_next_s;
  logic [1:0]         mode_r;
  logic               fs_q_r;
  logic [REC_W-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]   count_r, count_next_s;
  logic [IDX_W-1:0]   idx_r;
  logic [DEC_W-1:0]   decim_r;
  logic               ref_valid_r;
  logic [REC_W-1:0]   ref_r;
  logic               overflow_r;

  logic edge_s, qual_s, try_s, full_s, last_s, valid_s, acc_s, pop_s, wr_s, drop_s;
  logic [REC_W-1:0] head_s;

  assign edge_s  = frame_start & ~fs_q_r;
  assign qual_s  = edge_s & (state_r == S_RUN) &
                   ((mode_r != 2'd2) | ~ref_valid_r | (probe_data != ref_r));
  assign try_s   = qual_s & (decim_r == DEC_W'(0)) & ~arm;
  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign valid_s = (count_r != CNT_W'(0));
  assign last_s  = (idx_r == IDX_W'(NUM_CH - 1));
  assign acc_s   = valid_s & rd_ready & ~arm;
  assign pop_s   = acc_s & last_s;
  // A full FIFO still accepts a record when the head pops in the same cycle.
  assign wr_s    = try_s & (~full_s | pop_s);
  assign drop_s  = try_s & full_s & ~pop_s;
  assign head_s  = mem_r[rd_ptr_r];

  // Occupancy after this cycle's write/pop, used for the one-shot stop.
  always_comb begin
    count_next_s = count_r;
    case ({wr_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Next-state logic; arm restarts capture from any state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: if (arm) state_next_s = S_RUN; else state_next_s = S_IDLE;
      S_RUN: begin
        if (arm)                                                    state_next_s = S_RUN;
        else if (mode_r == 2'd1 && count_next_s == CNT_W'(DEPTH))   state_next_s = S_DONE;
        else                                                        state_next_s = S_RUN;
      end
      S_DONE: if (arm) state_next_s = S_RUN; else state_next_s = S_DONE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register, latched mode and frame_start edge history.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_r <= S_IDLE;
      mode_r  <= 2'd0;
      fs_q_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      fs_q_r  <= frame_start;
      if (arm) mode_r <= (mode_sel == 2'd3) ? 2'd0 : mode_sel;
      else     mode_r <= mode_r;
    end
  end

  // FIFO bookkeeping, read word index, decimation and change reference.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr_r    <= PTR_W'(0);
      rd_ptr_r    <= PTR_W'(0);
      count_r     <= CNT_W'(0);
      idx_r       <= IDX_W'(0);
      decim_r     <= DEC_W'(0);
      ref_valid_r <= 1'b0;
      ref_r       <= REC_W'(0);
      overflow_r  <= 1'b0;
    end else if (arm) begin
      wr_ptr_r    <= PTR_W'(0);
      rd_ptr_r    <= PTR_W'(0);
      count_r     <= CNT_W'(0);
      idx_r       <= IDX_W'(0);
      decim_r     <= DEC_W'(0);
      ref_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      count_r <= count_next_s;
      if (wr_s) begin
        wr_ptr_r    <= wr_ptr_r + PTR_W'(1);
        ref_valid_r <= 1'b1;
        ref_r       <= probe_data;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      if (acc_s) idx_r <= last_s ? IDX_W'(0) : idx_r + IDX_W'(1);
      if (qual_s) decim_r <= (decim_r == DEC_W'(DECIM - 1)) ? DEC_W'(0) : decim_r + DEC_W'(1);
      if (drop_s) overflow_r <= 1'b1;
    end
  end

  // Record storage.
  always_ff @(posedge clk) begin
    if (wr_s) mem_r[wr_ptr_r] <= probe_data;
  end

`ifdef PROBE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_r;
  logic [TS_W-1:0] ts_mem_r [DEPTH];

  // Free-running frame counter; arm deliberately leaves it alone.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in)   ts_r <= TS_W'(0);
    else if (edge_s) ts_r <= ts_r + TS_W'(1);
    else             ts_r <= ts_r;
  end

  // Timestamp storage alongside each record.
  always_ff @(posedge clk) begin
    if (wr_s) ts_mem_r[wr_ptr_r] <= ts_r;
  end

  assign rd_ts = valid_s ? ts_mem_r[rd_ptr_r] : TS_W'(0);
`else
  assign rd_ts = TS_W'(0);
`endif

  // Read-side and status outputs.
  always_comb begin
    rd_valid = valid_s;
    rd_data  = valid_s ? head_s[idx_r*CH_W +: CH_W] : CH_W'(0);
    rd_last  = valid_s & last_s;
    count    = count_r;
    overflow = overflow_r;
    busy     = (state_r == S_RUN);
  end

endmodule

// File: tb/tb_pong_probe_trace.sv
// Directed bench for pong_probe_trace; timestamp checks run when PROBE_TIMESTAMP_EN is defined.
module tb_pong_probe_trace;

  logic        clk = 1'b0;
  logic        reset_in = 1'b0;
  logic [39:0] probe_data = 40'd0;
  logic        frame_start = 1'b0;
  logic        arm = 1'b0;
  logic [1:0]  mode_sel = 2'd0;
  logic        rd_ready = 1'b0;
  logic        rd_ready_d = 1'b0;

  logic [9:0]  rd_data, rd_data_d;
  logic [3:0]  rd_ts, rd_ts_d;
  logic        rd_valid, rd_valid_d, rd_last, rd_last_d;
  logic [4:0]  count, count_d;
  logic        overflow, overflow_d, busy, busy_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pong_probe_trace #(.NUM_CH(4), .CH_W(10), .DEPTH(16), .DECIM(1), .TS_W(4)) dut (
    .clk(clk), .reset_in(reset_in), .probe_data(probe_data), .frame_start(frame_start),
    .arm(arm), .mode_sel(mode_sel), .rd_data(rd_data), .rd_ts(rd_ts), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last), .count(count), .overflow(overflow), .busy(busy));

  pong_probe_trace #(.NUM_CH(4), .CH_W(10), .DEPTH(16), .DECIM(3), .TS_W(4)) dut_d (
    .clk(clk), .reset_in(reset_in), .probe_data(probe_data), .frame_start(frame_start),
    .arm(arm), .mode_sel(mode_sel), .rd_data(rd_data_d), .rd_ts(rd_ts_d), .rd_valid(rd_valid_d),
    .rd_ready(rd_ready_d), .rd_last(rd_last_d), .count(count_d), .overflow(overflow_d), .busy(busy_d));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Channel k of record x carries x + 200*k.
  function automatic logic [39:0] mk(input int x);
    mk = {10'(x + 600), 10'(x + 400), 10'(x + 200), 10'(x)};
  endfunction

  task automatic frame(input int x);
    probe_data  = mk(x);
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    tick;
  endtask

  task automatic arm_mode(input logic [1:0] m);
    mode_sel = m;
    arm = 1'b1;
    tick;
    arm = 1'b0;
  endtask

  task automatic drain_rec(input int x);
    for (int k = 0; k < 4; k++) begin
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_data", 32'(rd_data), 32'(x + 200 * k));
      chk("rd_last", 32'(rd_last), (k == 3) ? 32'd1 : 32'd0);
      rd_ready = 1'b1;
      tick;
      rd_ready = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    tick; tick;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_last", 32'(rd_last), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_ts", 32'(rd_ts), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_in = 1'b1;
    tick;

    // Frames while IDLE are ignored
    frame(9);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Reset mid-RUN with 3 records stored
    arm_mode(2'd0);
    chk("arm_busy", 32'(busy), 32'd1);
    frame(1); frame(2); frame(3);
    chk("run3_count", 32'(count), 32'd3);
    chk("run3_head", 32'(rd_data), 32'd1);
    reset_in = 1'b0;
    tick;
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_valid", 32'(rd_valid), 32'd0);
    chk("mrst_data", 32'(rd_data), 32'd0);
    reset_in = 1'b1;
    tick;

`ifdef PROBE_TIMESTAMP_EN
    // Timestamps wrap at 16 while reads keep pace
    arm_mode(2'd0);
    for (int i = 0; i < 18; i++) begin
      frame(i);
      chk("ts", 32'(rd_ts), 32'(i % 16));
      drain_rec(i);
    end
`endif

    // Continuous mode overflow and in-order drain
    arm_mode(2'd0);
    for (int i = 0; i < 20; i++) frame(100 + i);
    chk("m0_count", 32'(count), 32'd16);
    chk("m0_ovf", 32'(overflow), 32'd1);
    tick;
    chk("m0_hold", 32'(rd_data), 32'd100);
    chk("m0_hold_last", 32'(rd_last), 32'd0);
    for (int r = 0; r < 16; r++) drain_rec(100 + r);
    chk("m0_empty_count", 32'(count), 32'd0);
    chk("m0_empty_valid", 32'(rd_valid), 32'd0);
    chk("m0_empty_data", 32'(rd_data), 32'd0);
    chk("m0_empty_last", 32'(rd_last), 32'd0);
    chk("m0_ovf_sticky", 32'(overflow), 32'd1);

    // One-shot mode stops at DEPTH
    arm_mode(2'd1);
    chk("m1_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) frame(30 + i);
    chk("m1_done_busy", 32'(busy), 32'd0);
    for (int i = 16; i < 20; i++) frame(30 + i);
    chk("m1_count", 32'(count), 32'd16);
    chk("m1_ovf", 32'(overflow), 32'd0);
    chk("m1_busy", 32'(busy), 32'd0);
    chk("m1_head", 32'(rd_data), 32'd30);
    arm_mode(2'd1);
    chk("m1_rearm_count", 32'(count), 32'd0);
    chk("m1_rearm_busy", 32'(busy), 32'd1);

    // Change-only mode
    arm_mode(2'd2);
    for (int i = 0; i < 5; i++) frame(7);
    frame(8);
    chk("m2_count", 32'(count), 32'd2);
    drain_rec(7);
    drain_rec(8);

    // Decimation by 3 on the second instance
    arm_mode(2'd0);
    for (int i = 0; i < 9; i++) frame(40 + i);
    chk("dec1_count", 32'(count), 32'd9);
    chk("dec3_count", 32'(count_d), 32'd3);
    chk("dec3_head", 32'(rd_data_d), 32'd40);

    // Full FIFO: last-word pop coincides with a capture edge
    arm_mode(2'd0);
    for (int i = 0; i < 16; i++) frame(i);
    chk("full_count", 32'(count), 32'd16);
    rd_ready = 1'b1;
    tick; tick; tick;
    chk("full_idx3_last", 32'(rd_last), 32'd1);
    probe_data  = mk(50);
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    rd_ready    = 1'b0;
    tick;
    chk("full_pop_count", 32'(count), 32'd16);
    chk("full_pop_ovf", 32'(overflow), 32'd0);
    for (int r = 1; r < 16; r++) drain_rec(r);
    drain_rec(50);
    chk("full_final_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
